// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer. It issues PC requests to a 1-cycle memory and queues the returned words in order, tagged with their PC. Optional macro: FETCH_BYPASS_EN.
// Latency: accept at cycle N gives inst_valid_o at N+2, or at N+1 with FETCH_BYPASS_EN.
// Backpressure: pc_ready_o drops when queued plus in-flight words reach DEPTH. A pop in the same cycle does not free a slot until the next cycle.
module inst_fetch_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_ready_o,
    output logic              imem_en_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic              flush_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [DATA_W-1:0] buf_dat [DEPTH];
    logic [ADDR_W-1:0] buf_pc  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;

    logic [CNT_W:0]    occ;
    logic              fifo_vld;
    logic              accept;
    logic              push;
    logic              pop;
    logic              clear;

    assign clear    = rst_i | flush_i;
    assign occ      = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign fifo_vld = (count != '0);

    assign pc_ready_o  = ~rst_i & ~flush_i & (occ < DEPTH_C);
    assign accept      = pc_valid_i & pc_ready_o;
    assign imem_en_o   = accept;
    assign imem_addr_o = pc_i;

`ifdef FETCH_BYPASS_EN
    logic byp_vld;

    // Returning word goes straight to decode when nothing older is queued.
    assign byp_vld = inflight & ~fifo_vld & ~clear;
    assign push    = inflight & ~clear & ~(byp_vld & inst_ready_i);
    assign pop     = fifo_vld & inst_ready_i & ~clear;

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = '0;
        inst_pc_o    = '0;
        if (fifo_vld) begin
            inst_valid_o = 1'b1;
            inst_o       = buf_dat[rd_ptr];
            inst_pc_o    = buf_pc[rd_ptr];
        end else if (byp_vld) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_data_i;
            inst_pc_o    = inflight_pc;
        end
    end
`else
    assign push = inflight & ~clear;
    assign pop  = fifo_vld & inst_ready_i & ~clear;

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = '0;
        inst_pc_o    = '0;
        if (fifo_vld) begin
            inst_valid_o = 1'b1;
            inst_o       = buf_dat[rd_ptr];
            inst_pc_o    = buf_pc[rd_ptr];
        end
    end
`endif

    // Storage needs no reset: occupancy is tracked entirely by count and the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_dat[wr_ptr] <= imem_data_i;
            buf_pc[wr_ptr]  <= inflight_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= accept;
            if (accept)
                inflight_pc <= pc_i;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed and randomised checks of inst_fetch_buffer in its default build, without the bypass path.
module tb_inst_fetch_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        pc_ready_o;
    logic        imem_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = 32'hDEADBEEF;
    logic        flush_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    int tests = 0;
    int fails = 0;

    inst_fetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_valid_i   (pc_valid_i),
        .pc_i         (pc_i),
        .pc_ready_o   (pc_ready_o),
        .imem_en_o    (imem_en_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .flush_i      (flush_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // The memory model returns a recognisable word derived from the address one cycle after a read.
    always @(posedge clk_i)
        imem_data_i <= imem_en_o ? {16'hA5A5, imem_addr_o[15:0]} : 32'hDEADBEEF;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] pc);
        check({tag, "_vld"}, 64'(inst_valid_o), 64'd1);
        check({tag, "_pc"}, 64'(inst_pc_o), 64'(pc));
        check({tag, "_dat"}, 64'(inst_o), {32'd0, 16'hA5A5, pc[15:0]});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vld"}, 64'(inst_valid_o), 64'd0);
        check({tag, "_dat"}, 64'(inst_o), 64'd0);
        check({tag, "_pc"}, 64'(inst_pc_o), 64'd0);
    endtask

    logic [31:0] q[$];
    logic        m_inf;
    logic [31:0] m_infpc;
    logic [31:0] next_pc;
    logic        e_rdy, e_vld, acc, popd, fl;

    initial begin
        rst_i = 1'b1; pc_valid_i = 1'b0; pc_i = '0; flush_i = 1'b0; inst_ready_i = 1'b0;
        tick; tick;
        #1;
        check_idle("reset");
        check("reset_rdy", 64'(pc_ready_o), 64'd0);
        rst_i = 1'b0;
        #1;
        check("rel_rdy", 64'(pc_ready_o), 64'd1);
        check("rel_en", 64'(imem_en_o), 64'd0);
        tick;

        // Back-to-back stream: four requests, decode always ready.
        inst_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pc_valid_i = (i < 4);
            pc_i = 32'(4 * i);
            #1;
            check("str_en", 64'(imem_en_o), 64'(i < 4));
            if (i >= 2 && i < 6) check_word("str", 32'(4 * (i - 2)));
            else check_idle("str_idle");
            tick;
        end

        // Backpressure: only four requests fit while decode stalls.
        inst_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc_valid_i = 1'b1;
            pc_i = 32'(4 * i);
            #1;
            check("bp_rdy", 64'(pc_ready_o), 64'(i < 4));
            tick;
        end
        // Full FIFO with a pop: the new request must wait one cycle.
        pc_i = 32'h40; inst_ready_i = 1'b1;
        #1;
        check("full_rdy", 64'(pc_ready_o), 64'd0);
        check("full_en", 64'(imem_en_o), 64'd0);
        check_word("bp0", 32'h0);
        tick;
        #1;
        check("pop_rdy", 64'(pc_ready_o), 64'd1);
        check("pop_addr", 64'(imem_addr_o), 64'h40);
        check_word("bp1", 32'h4);
        tick;
        pc_valid_i = 1'b0;
        #1; check_word("bp2", 32'h8); tick;
        #1; check_word("bp3", 32'hC); tick;
        #1; check_word("bp4", 32'h40); tick;
        #1; check_idle("bp_end"); tick;

        // Flush with three buffered words and one in flight.
        inst_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_valid_i = 1'b1;
            pc_i = 32'h20 + 32'(4 * i);
            tick;
        end
        flush_i = 1'b1; pc_i = 32'h30;
        #1;
        check("fl_rdy", 64'(pc_ready_o), 64'd0);
        check("fl_en", 64'(imem_en_o), 64'd0);
        tick;
        flush_i = 1'b0; pc_i = 32'h100; inst_ready_i = 1'b1;
        #1;
        check_idle("post_fl");
        check("post_fl_rdy", 64'(pc_ready_o), 64'd1);
        tick;
        pc_valid_i = 1'b0;
        #1; check_idle("post_fl2"); tick;
        #1; check_word("fl_new", 32'h100); tick;
        #1; check_idle("fl_end"); tick;

        // Reset in the middle of a stream.
        inst_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_valid_i = 1'b1;
            pc_i = 32'h200 + 32'(4 * i);
            tick;
        end
        rst_i = 1'b1;
        #1;
        check("rst_rdy", 64'(pc_ready_o), 64'd0);
        check("rst_en", 64'(imem_en_o), 64'd0);
        tick;
        #1; check_idle("rst1"); tick;
        #1; check_idle("rst2");
        rst_i = 1'b0; pc_valid_i = 1'b0; inst_ready_i = 1'b1;
        #1;
        check("rst_rel_rdy", 64'(pc_ready_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            #1; check_idle("rst_stale");
        end
        tick;

        // Random traffic against a queue-based model.
        m_inf = 1'b0; m_infpc = '0; next_pc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            pc_valid_i   = ($urandom_range(0, 3) != 0);
            inst_ready_i = ($urandom_range(0, 2) != 0);
            flush_i      = ($urandom_range(0, 40) == 0);
            pc_i         = next_pc;
            #1;
            fl    = flush_i;
            e_rdy = !fl && ((q.size() + int'(m_inf)) < 4);
            e_vld = (q.size() != 0);
            check("rnd_rdy", 64'(pc_ready_o), 64'(e_rdy));
            if (e_vld) check_word("rnd", q[0]);
            else check_idle("rnd_idle");
            acc  = pc_valid_i && e_rdy;
            popd = e_vld && inst_ready_i;
            tick;
            if (fl) begin
                q.delete();
                m_inf = 1'b0;
            end else begin
                if (popd) void'(q.pop_front());
                if (m_inf) q.push_back(m_infpc);
                m_inf = acc;
                m_infpc = pc_i;
                if (acc) next_pc = next_pc + 32'd4;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
